deinterleave_accumulator: RTL and testbench
===========================================

Name: deinterleave_accumulator

Overview:
- Scatter/accumulate counterpart of the forward interleaver used in backprop.
- Each cycle it accepts z per-weight-lane contributions plus the z interleaved neuron addresses for that cycle (same packing as the interleaver's memory_index_package), and adds each contribution into the addressed left-side neuron.
- After all fo*p/z cycles of a junction it drains the p accumulated neuron sums in natural neuron order, z per beat.

Parameters:
- fo, 2, fan-out of the junction (sweeps per junction); power of 2.
- p, 32, left-side neuron count; power of 2.
- z, 8, lanes (weights) processed per cycle; power of 2, z <= p.
- width, 16, signed two's-complement bits per input lane.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_data  in  width*z  lane j at [width*(j+1)-1 : width*j], signed.
- in_index_package  in  clog2(p)*z  lane j neuron index at [clog2(p)*(j+1)-1 : clog2(p)*j].
- out_valid  out  1  drain beat valid.
- out_ready  in  1  downstream accepts drain beat.
- out_data  out  (width+clog2(fo))*z  lane j = sum for neuron out_row*z+j, signed.
- out_row  out  clog2(p/z)  drain row index.
- done  out  1  one-cycle pulse on the final drain handshake.
- idx_err  out  1  sticky lane/bank mismatch flag.

Behaviour:
- Storage: z banks of p/z accumulators, each aw = width+clog2(fo) bits (fo=1 gives aw=width). Lane j always targets bank j. Row = index[j] >> clog2(z).
- Index check: index[j][clog2(z)-1:0] must equal j. On mismatch, idx_err sets and holds until reset; the write still proceeds to the row given by the high bits.
- States: ACCUM, DRAIN. Reset state is ACCUM.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Handshake is in_valid & in_ready.
  - beat counter bc runs 0..fo*p/z-1; sweep = bc >> clog2(p/z).
  - On each accepted beat, for every lane: if sweep==0, acc[j][row] <= sext(in_data[j]) (overwrite, so no clear phase is needed); otherwise acc[j][row] <= acc[j][row] + sext(in_data[j]).
  - All z lanes update in the same cycle. Lanes never collide because each lane owns its bank.
  - Two index entries in one beat never share a bank.
  - Gaps in in_valid stall bc; contents are held.
  - On the accepted beat with bc == fo*p/z-1: bc <= 0, state -> DRAIN, so out_valid rises the next cycle.
- DRAIN:
  - in_ready=0, out_valid=1.
  - out_row = drain counter dr, starting at 0; out_data lane j = acc[j][dr].
  - On out_valid & out_ready, dr increments. While out_ready=0, out_row and out_data hold stable.
  - On the handshake with dr == p/z-1: done=1 for that cycle, dr <= 0, state -> ACCUM, and in_ready=1 on the next cycle.
  - Accumulator contents are not altered during DRAIN.
- Arithmetic: signed, sign-extended to aw. No saturation is needed, since each accumulator receives exactly fo addends when the indices are a valid interleaving.
- Reset (at any time, including mid-ACCUM or mid-DRAIN):
  - State ACCUM; bc=0, dr=0.
  - in_ready=1, out_valid=0, done=0, idx_err=0, out_row=0.
  - out_data is don't-care while out_valid=0. Accumulator contents are not reset; stale values are overwritten by sweep 0.
- Latency: the first drain beat is presented 1 cycle after the last input beat is accepted. The minimum junction time is fo*p/z + p/z cycles.

Test Plan (fo=2, p=32, z=8, width=16, aw=17):
1. Identity indices (lane j, beat b: index = (b%4)*8+j), in_data all +1, 8 back-to-back beats -> 4 drain beats, out_row 0..3, every lane 17'd2; done pulses on the 4th handshake; idx_err stays 0.
2. Indices from interleaver_set (cycle_index 0..7), sweep-0 data +1, sweep-1 data -3 -> every lane of every drain row = 17'h1FFFE (-2); in_ready=0 throughout DRAIN.
3. Repeat test 1 with out_ready held low for 3 cycles at out_row=2 -> out_row/out_data stable at row 2 value 2 for those cycles; total of exactly 4 handshakes; single done pulse.
4. Repeat test 1 with in_valid toggled every other cycle -> same sums; out_valid rises exactly 1 cycle after the 8th accepted beat.
5. Beat 0, lane 3 index = 5'b00101 (low bits 5≠3) -> idx_err=1 from the next cycle and remains 1 through drain and the next junction until reset; bank 3 row 0 is written.
6. Fill 3 beats with 0x7FFF, assert reset, then run test 1 -> out_valid=0 and in_ready=1 immediately after reset; all drained sums = 2 (no stale data).

Source files
------------

// File: rtl/deinterleave_accumulator.sv
// Scatter/accumulate stage for backprop: each lane adds its contribution into the
// addressed neuron of its own bank, then the banks drain in natural neuron order.
module deinterleave_accumulator #(
  parameter int fo    = 2,
  parameter int p     = 32,
  parameter int z     = 8,
  parameter int width = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [width*z-1:0]                    in_data,
  input  logic [$clog2(p)*z-1:0]                in_index_package,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [(width+$clog2(fo))*z-1:0]       out_data,
  output logic [((p > z) ? $clog2(p/z) : 1)-1:0] out_row,
  output logic                                  done,
  output logic                                  idx_err
);

  localparam int IW    = $clog2(p);
  localparam int ZL    = $clog2(z);
  localparam int AW    = width + $clog2(fo);
  localparam int ROWS  = p / z;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BEATS = fo * ROWS;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bc_q, bc_d;
  logic [RW-1:0]   dr_q, dr_d;
  logic            err_q, err_d;
  logic            acc_we;
  logic            first_sweep;
  logic            lane_err;

  logic [AW-1:0]   acc_q  [z][ROWS];
  logic [AW-1:0]   wr_val [z];
  logic [RW-1:0]   row    [z];
  logic [IW-1:0]   idx    [z];
  logic [AW-1:0]   ext    [z];

  // Sweep 0 overwrites instead of adding, so no clear phase is needed between junctions.
  assign first_sweep = (32'(bc_q) < ROWS);

  always_comb begin
    lane_err = 1'b0;
    for (int unsigned j = 0; j < z; j++) begin
      idx[j]    = in_index_package[j*IW +: IW];
      row[j]    = RW'(idx[j] >> ZL);
      lane_err  = lane_err | ((32'(idx[j]) & (z - 1)) != j);
      ext[j]    = AW'($signed(in_data[j*width +: width]));
      wr_val[j] = first_sweep ? ext[j] : acc_q[j][row[j]] + ext[j];
    end
  end

  always_comb begin
    state_d   = state_q;
    bc_d      = bc_q;
    dr_d      = dr_q;
    err_d     = err_q;
    acc_we    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_we = 1'b1;
          err_d  = err_q | lane_err;
          if (bc_q == BW'(BEATS - 1)) begin
            bc_d    = '0;
            state_d = DRAIN;
          end else begin
            bc_d = bc_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (dr_q == RW'(ROWS - 1)) begin
            done    = 1'b1;
            dr_d    = '0;
            state_d = ACCUM;
          end else begin
            dr_d = dr_q + 1'b1;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
      bc_q    <= '0;
      dr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      dr_q    <= dr_d;
      err_q   <= err_d;
    end
  end

  // Accumulator storage is deliberately unreset; stale contents die on the next sweep 0.
  always_ff @(posedge clk) begin
    if (acc_we) begin
      for (int unsigned j = 0; j < z; j++) begin
        acc_q[j][row[j]] <= wr_val[j];
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < z; j++) begin
      out_data[j*AW +: AW] = acc_q[j][dr_q];
    end
  end

  assign out_row = dr_q;
  assign idx_err = err_q;

endmodule

// File: tb/tb_deinterleave_accumulator.sv
// Directed bench for deinterleave_accumulator at fo=2, p=32, z=8, width=16 (aw=17).
module tb_deinterleave_accumulator;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [39:0]  in_index_package;
  logic         out_valid;
  logic         out_ready;
  logic [135:0] out_data;
  logic [1:0]   out_row;
  logic         done;
  logic         idx_err;

  int nvec = 0;
  int nerr = 0;

  deinterleave_accumulator #(.fo(2), .p(32), .z(8), .width(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_index_package (in_index_package),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_row          (out_row),
    .done             (done),
    .idx_err          (idx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: identity rows; mode 1: a scrambled but valid interleaving per sweep
  task automatic set_beat(input int b, input int mode, input logic [15:0] val);
    int r;
    for (int j = 0; j < 8; j++) begin
      if (mode == 0) r = b % 4;
      else if (b < 4) r = (b + j) % 4;
      else r = (3 * b + j + 1) % 4;
      in_data[j*16 +: 16]         = val;
      in_index_package[j*5 +: 5]  = 5'(r * 8 + j);
    end
  endtask

  task automatic feed_junction(input int mode, input logic [15:0] v0, input logic [15:0] v1,
                               input bit gaps);
    for (int b = 0; b < 8; b++) begin
      set_beat(b, mode, (b < 4) ? v0 : v1);
      in_valid = 1'b1;
      nvec++;
      if (in_ready !== 1'b1) begin
        nerr++;
        $display("FAIL feed_in_ready beat %0d: got %b want 1", b, in_ready);
      end
      step();
      if (gaps && b < 7) begin
        in_valid = 1'b0;
        nvec++;
        if (out_valid !== 1'b0) begin
          nerr++;
          $display("FAIL gap_out_valid beat %0d: got %b want 0", b, out_valid);
        end
        step();
      end
    end
    in_valid = 1'b0;
    nvec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL drain_entry: out_valid %b in_ready %b want 1 0", out_valid, in_ready);
    end
  endtask

  task automatic drain_junction(input logic [16:0] exp, input int stall_row, input int stall_cyc);
    for (int r = 0; r < 4; r++) begin
      if (r == stall_row) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_cyc; s++) begin
          nvec++;
          if (out_valid !== 1'b1 || out_row !== 2'(r) || done !== 1'b0 || in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL stall_ctrl row %0d: valid %b row %0d done %b ready %b", r, out_valid,
                     out_row, done, in_ready);
          end
          for (int j = 0; j < 8; j++) begin
            nvec++;
            if (out_data[j*17 +: 17] !== exp) begin
              nerr++;
              $display("FAIL stall_data row %0d lane %0d: got %h want %h", r, j,
                       out_data[j*17 +: 17], exp);
            end
          end
          step();
        end
      end
      out_ready = 1'b1;
      nvec++;
      if (out_valid !== 1'b1 || out_row !== 2'(r) || in_ready !== 1'b0 || done !== (r == 3)) begin
        nerr++;
        $display("FAIL drain_ctrl row %0d: valid %b row %0d ready %b done %b", r, out_valid,
                 out_row, in_ready, done);
      end
      for (int j = 0; j < 8; j++) begin
        nvec++;
        if (out_data[j*17 +: 17] !== exp) begin
          nerr++;
          $display("FAIL drain_data row %0d lane %0d: got %h want %h", r, j,
                   out_data[j*17 +: 17], exp);
        end
      end
      step();
    end
    out_ready = 1'b0;
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || out_row !== 2'd0) begin
      nerr++;
      $display("FAIL drain_exit: valid %b ready %b done %b row %0d want 0 1 0 0", out_valid,
               in_ready, done, out_row);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 || idx_err !== 1'b0 ||
        out_row !== 2'd0) begin
      nerr++;
      $display("FAIL reset_state: ready %b valid %b done %b err %b row %0d", in_ready, out_valid,
               done, idx_err, out_row);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_identity();
    feed_junction(0, 16'd1, 16'd1, 1'b0);
    drain_junction(17'd2, -1, 0);
    nvec++;
    if (idx_err !== 1'b0) begin
      nerr++;
      $display("FAIL identity_idx_err: got %b want 0", idx_err);
    end
  endtask

  task automatic test_interleaved();
    feed_junction(1, 16'd1, 16'hFFFD, 1'b0);
    drain_junction(17'h1FFFE, -1, 0);
  endtask

  task automatic test_backpressure();
    feed_junction(0, 16'd1, 16'd1, 1'b0);
    drain_junction(17'd2, 2, 3);
  endtask

  task automatic test_gaps();
    feed_junction(0, 16'd1, 16'd1, 1'b1);
    drain_junction(17'd2, -1, 0);
  endtask

  task automatic test_idx_err();
    for (int b = 0; b < 8; b++) begin
      set_beat(b, 0, 16'd1);
      if (b == 0) in_index_package[3*5 +: 5] = 5'b00101;
      in_valid = 1'b1;
      step();
      nvec++;
      if (idx_err !== 1'b1) begin
        nerr++;
        $display("FAIL idx_err_set beat %0d: got %b want 1", b, idx_err);
      end
    end
    in_valid = 1'b0;
    drain_junction(17'd2, -1, 0);
    feed_junction(0, 16'd1, 16'd1, 1'b0);
    drain_junction(17'd2, -1, 0);
    nvec++;
    if (idx_err !== 1'b1) begin
      nerr++;
      $display("FAIL idx_err_sticky: got %b want 1", idx_err);
    end
    test_reset();
    nvec++;
    if (idx_err !== 1'b0) begin
      nerr++;
      $display("FAIL idx_err_clear: got %b want 0", idx_err);
    end
  endtask

  task automatic test_reset_mid_accum();
    for (int b = 0; b < 3; b++) begin
      set_beat(b, 0, 16'h7FFF);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    test_reset();
    test_identity();
  endtask

  initial begin
    reset            = 1'b1;
    in_valid         = 1'b0;
    out_ready        = 1'b0;
    in_data          = '0;
    in_index_package = '0;
    #2;
    test_reset();
    test_identity();
    test_interleaved();
    test_backpressure();
    test_gaps();
    test_idx_err();
    test_reset_mid_accum();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
